// File: rtl/sig_gen_pkg.sv
// Shared types and default widths for the signal generator.
package sig_gen_pkg;

  localparam int PHASE_W_DEF  = 32;
  localparam int SAMPLE_W_DEF = 16;
  localparam int DIV_W_DEF    = 16;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_DC     = 2'd3
  } wave_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sig_gen_shaper.sv
// Waveform shaping and amplitude scaling; purely combinational.
// The sample is floor(raw * amplitude / 2^16), so negative results round down.
module sig_gen_shaper import sig_gen_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic [15:0]         phase_msb_i,
  input  logic [1:0]          wave_sel_i,
  input  logic [SAMPLE_W-1:0] amplitude_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic [15:0]                raw;
  logic [15:0]                tri_u;
  logic signed [SAMPLE_W+15:0] product;

  // Select the raw signed waveform and apply the unsigned gain
  always_comb begin
    tri_u = phase_msb_i[15] ? ~{phase_msb_i[14:0], 1'b0} : {phase_msb_i[14:0], 1'b0};
    case (wave_sel_i)
      WAVE_SQUARE: raw = phase_msb_i[15] ? 16'h8000 : 16'h7FFF;
      WAVE_SAW:    raw = phase_msb_i ^ 16'h8000;
      WAVE_TRI:    raw = tri_u ^ 16'h8000;
      default:     raw = 16'h7FFF;
    endcase
    // |raw * amp| < 2^(SAMPLE_W+15), so SAMPLE_W+16 signed bits cannot overflow
    product = $signed(raw) * $signed({1'b0, amplitude_i});
  end

  assign sample_o = SAMPLE_W'(product >>> 16);

endmodule

// File: rtl/sig_gen_core.sv
// Phase-accumulator signal generator with rate divider, double-buffered
// configuration and a one-deep valid/ready output register.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no ticks; pending configuration is copied to active at once
//   ST_RUN  | tick counter runs; each tick produces one sample
module sig_gen_core import sig_gen_pkg::*; #(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ctrl_enable,
  input  logic                cfg_update,
  input  logic [1:0]          cfg_wave_sel,
  input  logic [PHASE_W-1:0]  cfg_phase_inc,
  input  logic [SAMPLE_W-1:0] cfg_amplitude,
  input  logic [DIV_W-1:0]    cfg_rate_div,
  input  logic                clear_ovr,
  output logic                m_valid,
  output logic [SAMPLE_W-1:0] m_data,
  input  logic                m_ready,
  output logic                running,
  output logic                overrun,
  output logic [31:0]         sample_count
);

  state_e state_q, state_d;
  logic in_run, leave_run, enter_run;

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [1:0]          stg_wave_q, stg_wave_d, act_wave_q, act_wave_d;
  logic [PHASE_W-1:0]  stg_inc_q, stg_inc_d, act_inc_q, act_inc_d;
  logic [SAMPLE_W-1:0] stg_amp_q, stg_amp_d, act_amp_q, act_amp_d;
  logic [DIV_W-1:0]    stg_div_q, stg_div_d, act_div_q, act_div_d;
  logic                pending_q, pending_d;
  logic                m_valid_q, m_valid_d;
  logic [SAMPLE_W-1:0] m_data_q, m_data_d;
  logic                overrun_q, overrun_d;
  logic [31:0]         count_q, count_d;

  logic                tick, apply, xfer, drop;
  logic [1:0]          eff_wave;
  logic [PHASE_W-1:0]  eff_inc;
  logic [SAMPLE_W-1:0] eff_amp;
  logic [SAMPLE_W-1:0] shaped;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: enable level alone moves between IDLE and RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_enable)  state_d = ST_RUN;
      ST_RUN:  if (!ctrl_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM decodes used by the datapath
  always_comb begin
    in_run    = (state_q == ST_RUN);
    enter_run = (state_q == ST_IDLE) && ctrl_enable;
    leave_run = in_run && !ctrl_enable;
  end

  sig_gen_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
    .phase_msb_i (phase_q[PHASE_W-1 -: 16]),
    .wave_sel_i  (eff_wave),
    .amplitude_i (eff_amp),
    .sample_o    (shaped)
  );

  // Tick generation, config staging, accumulator and output handshake
  always_comb begin
    tick  = in_run && (cnt_q == act_div_q);
    // pending_q is only visible from the cycle after capture, so a capture
    // coinciding with a tick is naturally deferred to the next tick
    apply = pending_q && (tick || !in_run);

    eff_wave = (tick && pending_q) ? stg_wave_q : act_wave_q;
    eff_inc  = (tick && pending_q) ? stg_inc_q  : act_inc_q;
    eff_amp  = (tick && pending_q) ? stg_amp_q  : act_amp_q;

    cnt_d = (!in_run || leave_run || tick) ? '0 : cnt_q + DIV_W'(1);

    phase_d = phase_q;
    if (enter_run) phase_d = '0;
    else if (tick) phase_d = phase_q + eff_inc;

    stg_wave_d = cfg_update ? cfg_wave_sel  : stg_wave_q;
    stg_inc_d  = cfg_update ? cfg_phase_inc : stg_inc_q;
    stg_amp_d  = cfg_update ? cfg_amplitude : stg_amp_q;
    stg_div_d  = cfg_update ? cfg_rate_div  : stg_div_q;

    act_wave_d = apply ? stg_wave_q : act_wave_q;
    act_inc_d  = apply ? stg_inc_q  : act_inc_q;
    act_amp_d  = apply ? stg_amp_q  : act_amp_q;
    act_div_d  = apply ? stg_div_q  : act_div_q;

    pending_d = cfg_update ? 1'b1 : (apply ? 1'b0 : pending_q);

    xfer = m_valid_q && m_ready;
    drop = tick && m_valid_q && !m_ready;

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (tick && !drop) begin
      m_valid_d = 1'b1;
      m_data_d  = shaped;
    end else if (xfer) begin
      m_valid_d = 1'b0;
    end

    overrun_d = drop ? 1'b1 : (clear_ovr ? 1'b0 : overrun_q);
    count_d   = xfer ? count_q + 32'd1 : count_q;
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      stg_wave_q <= '0;
      stg_inc_q  <= '0;
      stg_amp_q  <= '0;
      stg_div_q  <= '0;
      act_wave_q <= '0;
      act_inc_q  <= '0;
      act_amp_q  <= '0;
      act_div_q  <= '0;
      pending_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      stg_wave_q <= stg_wave_d;
      stg_inc_q  <= stg_inc_d;
      stg_amp_q  <= stg_amp_d;
      stg_div_q  <= stg_div_d;
      act_wave_q <= act_wave_d;
      act_inc_q  <= act_inc_d;
      act_amp_q  <= act_amp_d;
      act_div_q  <= act_div_d;
      pending_q  <= pending_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign running      = in_run;
  assign overrun      = overrun_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_sig_gen_core.sv
// Bench for sig_gen_core: waveform vector table plus timing/corner sequences.
module tb_sig_gen_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_enable = 1'b0;
  logic        cfg_update = 1'b0;
  logic [1:0]  cfg_wave_sel = '0;
  logic [31:0] cfg_phase_inc = '0;
  logic [15:0] cfg_amplitude = '0;
  logic [15:0] cfg_rate_div = '0;
  logic        clear_ovr = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        running;
  logic        overrun;
  logic [31:0] sample_count;

  sig_gen_core dut (
    .clock(clock), .reset(reset), .ctrl_enable(ctrl_enable),
    .cfg_update(cfg_update), .cfg_wave_sel(cfg_wave_sel),
    .cfg_phase_inc(cfg_phase_inc), .cfg_amplitude(cfg_amplitude),
    .cfg_rate_div(cfg_rate_div), .clear_ovr(clear_ovr),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .running(running), .overrun(overrun), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wave;
    logic [31:0] inc;
    logic [15:0] amp;
    int          exp_s [4];
  } vec_t;

  vec_t vecs [6];
  int   sb_q [$];
  int   sb_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] w, input logic [31:0] inc,
                              input logic [15:0] a, input int e0, input int e1,
                              input int e2, input int e3);
    vec_t v;
    v.wave = w; v.inc = inc; v.amp = a;
    v.exp_s[0] = e0; v.exp_s[1] = e1; v.exp_s[2] = e2; v.exp_s[3] = e3;
    return v;
  endfunction

  // Scoreboard: every transfer pops and compares the next expected sample
  always @(negedge clock) begin
    if (!reset && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got sample %0d expected no transfer (t=%0t)",
                 $signed(m_data), $time);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_sample", $signed(m_data), sb_exp);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_idle(input logic [1:0] w, input logic [31:0] inc,
                          input logic [15:0] a, input logic [15:0] div);
    step();
    cfg_wave_sel = w; cfg_phase_inc = inc; cfg_amplitude = a; cfg_rate_div = div;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    step();
    step();
  endtask

  task automatic drain_check(input string name);
    repeat (4) step();
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(2'd1, 32'h4000_0000, 16'hFFFF, -32768, -16384, 0, 16383);
    vecs[1] = mk(2'd0, 32'h8000_0000, 16'h8000, 16383, -16384, 16383, -16384);
    vecs[2] = mk(2'd2, 32'h4000_0000, 16'hFFFF, -32768, 0, 32766, -1);
    vecs[3] = mk(2'd3, 32'h1234_5678, 16'h4000, 8191, 8191, 8191, 8191);
    vecs[4] = mk(2'd1, 32'h4000_0000, 16'h0001, -1, -1, 0, 0);
    vecs[5] = mk(2'd2, 32'h2000_0000, 16'h8000, -16384, -8192, 0, 8192);

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_running", running, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", sample_count, 0);

    // Waveform table: rate_div 0, four samples per vector
    for (int v = 0; v < 6; v++) begin
      cfg_idle(vecs[v].wave, vecs[v].inc, vecs[v].amp, 16'd0);
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) sb_q.push_back(vecs[v].exp_s[k]);
      step();
      ctrl_enable = 1'b1;
      repeat (4) step();
      ctrl_enable = 1'b0;
      drain_check("vec_drain");
    end

    // Square timing: one valid pulse every 5 cycles
    cfg_idle(2'd0, 32'h8000_0000, 16'h8000, 16'd4);
    m_ready = 1'b1;
    sb_q.push_back(16383); sb_q.push_back(-16384);
    sb_q.push_back(16383); sb_q.push_back(-16384);
    step();
    ctrl_enable = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("sq_valid", m_valid, (i >= 6 && (i - 6) % 5 == 0));
      if (i == 1) check("sq_running", running, 1);
    end
    step();
    ctrl_enable = 1'b0;
    drain_check("sq_drain");

    // Mid-run reconfiguration: off-tick capture, then capture on a tick
    cfg_idle(2'd1, 32'h4000_0000, 16'hFFFF, 16'd1);
    m_ready = 1'b1;
    sb_q.push_back(-32768); sb_q.push_back(-16384); sb_q.push_back(-12288);
    sb_q.push_back(-8192);  sb_q.push_back(-4096);  sb_q.push_back(4095);
    step();
    ctrl_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      cfg_update = (i == 3 || i == 8);
      if (i == 3) cfg_phase_inc = 32'h1000_0000;
      if (i == 8) cfg_phase_inc = 32'h2000_0000;
      if (i == 12) ctrl_enable = 1'b0;
    end
    drain_check("rcfg_drain");

    // Backpressure: held data, overrun on second tick, set beats clear
    cfg_idle(2'd1, 32'h4000_0000, 16'hFFFF, 16'd3);
    m_ready = 1'b0;
    step();
    ctrl_enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock);
      #1 clear_ovr = (i == 8);
      @(negedge clock);
      check("bp_valid", m_valid, (i >= 5));
      if (i >= 5) check("bp_data_hold", $signed(m_data), -32768);
      check("bp_overrun", overrun, (i >= 9));
    end
    sb_q.push_back(-32768); sb_q.push_back(16383);
    step();
    m_ready = 1'b1;
    repeat (4) step();
    ctrl_enable = 1'b0;
    drain_check("bp_drain");
    check("bp_ovr_sticky", overrun, 1);
    step();
    clear_ovr = 1'b1;
    step();
    clear_ovr = 1'b0;
    @(negedge clock);
    check("bp_ovr_clear", overrun, 0);

    // Restart: held sample survives IDLE, phase restarts at 0
    cfg_idle(2'd1, 32'h4000_0000, 16'hFFFF, 16'd0);
    m_ready = 1'b0;
    step();
    ctrl_enable = 1'b1;
    step();
    step();
    ctrl_enable = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("rs_hold_valid", m_valid, 1);
    check("rs_hold_data", $signed(m_data), -32768);
    check("rs_idle", running, 0);
    check("rs_overrun", overrun, 1);
    sb_q.push_back(-32768); sb_q.push_back(-32768); sb_q.push_back(-16384);
    step();
    m_ready = 1'b1;
    ctrl_enable = 1'b1;
    step();
    step();
    ctrl_enable = 1'b0;
    drain_check("rs_drain");
    @(negedge clock);
    check("count_total", sample_count, 39);

    // Reset mid-run while a sample is stalled
    m_ready = 1'b0;
    step();
    ctrl_enable = 1'b1;
    repeat (3) step();
    @(negedge clock);
    check("mr_pre_valid", m_valid, 1);
    check("mr_pre_overrun", overrun, 1);
    step();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mr_valid", m_valid, 0);
    check("mr_data", m_data, 0);
    check("mr_running", running, 0);
    check("mr_overrun", overrun, 0);
    check("mr_count", sample_count, 0);
    step();
    reset = 1'b0;
    ctrl_enable = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
